// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED PIO sequencer.
// Contents: config register word addresses, CTRL field bit positions and
// the pattern-engine mode encoding.
package led_seq_pkg;

  // Config slave word addresses
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // CTRL register field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;

  // Pattern engine modes as stored in CTRL[2:1]
  typedef enum logic [1:0] {
    STATIC = 2'd0,
    BLINK  = 2'd1,
    ROTATE = 2'd2,
    BOUNCE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_pattern_step.sv
// Combinational next-step function of the LED pattern engine.
// Ports:
//   cur        current LED pattern
//   dir        bounce direction (0 = moving left/towards MSB, 1 = right)
//   phase      blink phase (0 = pattern shown, 1 = dark)
//   mode       CTRL mode field (static, blink, rotate, bounce)
//   pattern    PATTERN register, the value shown in the lit blink phase
//   cur_next   pattern after one step
//   dir_next   bounce direction after one step
//   phase_next blink phase after one step
module led_pattern_step
  import led_seq_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic [LED_W-1:0] cur,
  input  logic             dir,
  input  logic             phase,
  input  logic [1:0]       mode,
  input  logic [LED_W-1:0] pattern,
  output logic [LED_W-1:0] cur_next,
  output logic             dir_next,
  output logic             phase_next
);

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  // Next-step computation for each mode; state holds unless a mode changes it
  always_comb begin
    cur_next   = cur;
    dir_next   = dir;
    phase_next = phase;
    case (mode_s)
      STATIC: begin
        cur_next = cur;
      end
      BLINK: begin
        phase_next = ~phase;
        // Entering phase 1 blanks the LEDs, entering phase 0 relights them
        if (phase == 1'b0) begin
          cur_next = {LED_W{1'b0}};
        end else begin
          cur_next = pattern;
        end
      end
      ROTATE: begin
        cur_next = {cur[LED_W-2:0], cur[LED_W-1]};
      end
      BOUNCE: begin
        // At an edge the direction reverses and the same step moves back
        // inward, so the end LED is shown for exactly one step.
        if (dir == 1'b0) begin
          if (cur[LED_W-1] == 1'b1) begin
            dir_next = 1'b1;
            cur_next = {1'b0, cur[LED_W-1:1]};
          end else begin
            cur_next = {cur[LED_W-2:0], 1'b0};
          end
        end else begin
          if (cur[0] == 1'b1) begin
            dir_next = 1'b0;
            cur_next = {cur[LED_W-2:0], 1'b0};
          end else begin
            cur_next = {1'b0, cur[LED_W-1:1]};
          end
        end
      end
      default: begin
        cur_next = cur;
      end
    endcase
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// Avalon-MM LED pattern sequencer; sole master of the LED PIO s1 port.
// A prescaler produces a step tick every PERIOD+1 cycles while enabled;
// each non-static step, and every config write, pushes the current pattern
// to PIO register 0 with a one-cycle registered write strobe.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   address/chipselect/write_n/writedata/readdata
//                              config slave (CTRL, PERIOD, PATTERN, STATUS)
//   pio_address                PIO register address, always 0
//   pio_chipselect/pio_write_n registered PIO write strobes
//   pio_writedata              registered PIO data, zero-extended pattern
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int          LED_W          = 8,
  parameter int          PRESCALE_W     = 32,
  parameter int unsigned DEFAULT_PERIOD = 32'd24999999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  localparam logic [PRESCALE_W-1:0] CNT_ONE    = PRESCALE_W'(1'b1);
  localparam logic [PRESCALE_W-1:0] PERIOD_RST = PRESCALE_W'(DEFAULT_PERIOD);

  logic                  ctrl_en_r;
  logic [1:0]            ctrl_mode_r;
  logic [PRESCALE_W-1:0] period_r;
  logic [LED_W-1:0]      pattern_r;
  logic [PRESCALE_W-1:0] cnt_r;
  logic [LED_W-1:0]      cur_r;
  logic                  dir_r;
  logic                  phase_r;
  logic                  pio_cs_r;
  logic                  pio_wn_r;
  logic [31:0]           pio_wd_r;

  logic                  cfg_wr_s;
  logic                  cfg_reload_s;
  logic                  tick_s;
  logic                  step_wr_s;
  logic [LED_W-1:0]      reload_val_s;
  logic [LED_W-1:0]      cur_next_s;
  logic                  dir_next_s;
  logic                  phase_next_s;

  // STATUS is read-only, so a write there neither changes state nor reloads
  assign cfg_wr_s     = chipselect & ~write_n;
  assign cfg_reload_s = cfg_wr_s & (address != REG_STATUS);
  assign tick_s       = ctrl_en_r & (cnt_r == period_r);
  assign step_wr_s    = tick_s & (mode_e'(ctrl_mode_r) != STATIC);

  // Reload value: a PATTERN write takes effect in the same reload
  always_comb begin
    reload_val_s = pattern_r;
    if (address == REG_PATTERN) begin
      reload_val_s = writedata[LED_W-1:0];
    end else begin
      reload_val_s = pattern_r;
    end
  end

  led_pattern_step #(
    .LED_W(LED_W)
  ) u_step (
    .cur        (cur_r),
    .dir        (dir_r),
    .phase      (phase_r),
    .mode       (ctrl_mode_r),
    .pattern    (pattern_r),
    .cur_next   (cur_next_s),
    .dir_next   (dir_next_s),
    .phase_next (phase_next_s)
  );

  // Config register file
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_r   <= 1'b0;
      ctrl_mode_r <= 2'd0;
      period_r    <= PERIOD_RST;
      pattern_r   <= {LED_W{1'b0}};
    end else if (cfg_wr_s) begin
      case (address)
        REG_CTRL: begin
          ctrl_en_r   <= writedata[CTRL_EN_BIT];
          ctrl_mode_r <= writedata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        end
        REG_PERIOD:  period_r  <= writedata[PRESCALE_W-1:0];
        REG_PATTERN: pattern_r <= writedata[LED_W-1:0];
        default: begin
          ctrl_en_r <= ctrl_en_r;
        end
      endcase
    end
  end

  // Prescaler: restarts on reload, wrap, or while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (cfg_reload_s || !ctrl_en_r || tick_s) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Pattern state; a config write takes priority over a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r   <= {LED_W{1'b0}};
      dir_r   <= 1'b0;
      phase_r <= 1'b0;
    end else if (cfg_reload_s) begin
      cur_r   <= reload_val_s;
      dir_r   <= 1'b0;
      phase_r <= 1'b0;
    end else if (tick_s) begin
      cur_r   <= cur_next_s;
      dir_r   <= dir_next_s;
      phase_r <= phase_next_s;
    end
  end

  // PIO write strobe: one cycle per reload or non-static step
  always_ff @(posedge clk) begin
    if (reset) begin
      pio_cs_r <= 1'b0;
      pio_wn_r <= 1'b1;
      pio_wd_r <= 32'h0000_0000;
    end else if (cfg_reload_s) begin
      pio_cs_r <= 1'b1;
      pio_wn_r <= 1'b0;
      pio_wd_r <= {{(32-LED_W){1'b0}}, reload_val_s};
    end else if (step_wr_s) begin
      pio_cs_r <= 1'b1;
      pio_wn_r <= 1'b0;
      pio_wd_r <= {{(32-LED_W){1'b0}}, cur_next_s};
    end else begin
      pio_cs_r <= 1'b0;
      pio_wn_r <= 1'b1;
    end
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = pio_cs_r;
  assign pio_write_n    = pio_wn_r;
  assign pio_writedata  = pio_wd_r;

  // Config read mux; unused bits read as zero
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_EN_BIT]                 = ctrl_en_r;
        readdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = ctrl_mode_r;
      end
      REG_PERIOD:  readdata[PRESCALE_W-1:0] = period_r;
      REG_PATTERN: readdata[LED_W-1:0]      = pattern_r;
      REG_STATUS:  readdata[LED_W+1:0]      = {phase_r, dir_r, cur_r};
      default:     readdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer. A behavioural model tracks
// registers, the cycles elapsed since the last restart and the displayed
// pattern with plain integer arithmetic, and predicts every PIO write.
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pio_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  // ---------------- reference model ----------------
  bit          m_en;
  int unsigned m_mode;
  int unsigned m_period;
  int unsigned m_pattern;
  int unsigned m_cur;
  int unsigned m_since;
  bit          m_dir;
  bit          m_phase;
  bit          exp_wr;
  int unsigned exp_wd;
  int unsigned cyc = 0;

  function automatic int unsigned exp_read(int unsigned a);
    case (a)
      0:       return (m_en ? 1 : 0) + 2 * m_mode;
      1:       return m_period;
      2:       return m_pattern;
      default: return m_cur + (m_dir ? 256 : 0) + (m_phase ? 512 : 0);
    endcase
  endfunction

  task automatic model_advance();
    case (m_mode)
      1: begin
        m_phase = !m_phase;
        m_cur   = m_phase ? 0 : m_pattern;
      end
      2: m_cur = (m_cur * 2) % 256 + m_cur / 128;
      3: begin
        if (!m_dir) begin
          if (m_cur >= 128) begin m_dir = 1'b1; m_cur = m_cur / 2; end
          else m_cur = (m_cur * 2) % 256;
        end else begin
          if (m_cur % 2 == 1) begin m_dir = 1'b0; m_cur = (m_cur * 2) % 256; end
          else m_cur = m_cur / 2;
        end
      end
      default: m_cur = m_cur;
    endcase
  endtask

  // Called at each rising edge with the inputs that edge samples
  task automatic model_edge();
    if (reset) begin
      m_en = 1'b0; m_mode = 0; m_period = 24999999; m_pattern = 0;
      m_cur = 0; m_since = 0; m_dir = 1'b0; m_phase = 1'b0;
      exp_wr = 1'b0; exp_wd = 0;
      return;
    end
    exp_wr = 1'b0;
    if (chipselect && !write_n && address != 2'd3) begin
      if (address == 2'd0) begin
        m_en = writedata[0]; m_mode = int'(writedata[2:1]);
      end else if (address == 2'd1) begin
        m_period = writedata;
      end else begin
        m_pattern = int'(writedata[7:0]);
      end
      m_cur = m_pattern; m_since = 0; m_dir = 1'b0; m_phase = 1'b0;
      exp_wr = 1'b1; exp_wd = m_cur;
    end else if (!m_en) begin
      m_since = 0;
    end else if (m_since < m_period) begin
      m_since = m_since + 1;
    end else begin
      m_since = 0;
      if (m_mode != 0) begin
        model_advance();
        exp_wr = 1'b1; exp_wd = m_cur;
      end
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    cyc = cyc + 1;
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    clk_cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    clk_cycle(); clk_cycle();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      checks++;
      if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got cs=%b wn=%b addr=%b want cs=0 wn=1 addr=0",
                 cyc, pio_chipselect, pio_write_n, pio_address);
      end
    end
    address = 2'd3; #1;
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL reset_status got %h want 0", readdata);
    end
    address = 2'd1; #1;
    checks++;
    if (readdata !== 32'd24999999) begin
      errors++; $display("FAIL reset_period got %0d want 24999999", readdata);
    end
    address = 2'd0; #1;
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", readdata);
    end
  endtask

  task automatic test_rotate();
    int unsigned rot_exp[9] = '{2, 4, 8, 16, 32, 64, 128, 1, 2};
    int unsigned wq[$];
    int unsigned wc[$];
    int unsigned start;
    cfg_write(2'd1, 32'd3);
    cfg_write(2'd2, 32'h01);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_writedata !== 32'h01) begin
      errors++;
      $display("FAIL rotate_load got cs=%b wn=%b wd=%h want cs=1 wn=0 wd=01",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    cfg_write(2'd0, 32'd5);
    start = cyc;
    for (int i = 0; i < 40; i++) begin
      clk_cycle();
      checks++;
      if (pio_chipselect !== exp_wr || pio_write_n !== !exp_wr || (exp_wr && pio_writedata !== exp_wd)) begin
        errors++;
        $display("FAIL rotate_pio cyc=%0d got cs=%b wn=%b wd=%h want cs=%b wd=%h",
                 cyc, pio_chipselect, pio_write_n, pio_writedata, exp_wr, exp_wd);
      end
      if (pio_chipselect === 1'b1) begin
        wq.push_back(pio_writedata); wc.push_back(cyc);
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= wq.size()) begin
        errors++; $display("FAIL rotate_seq[%0d] got no write want %h", i, rot_exp[i]);
      end else if (wq[i] != rot_exp[i] || wc[i] != start + 4 * (i + 1)) begin
        errors++;
        $display("FAIL rotate_seq[%0d] got %h at +%0d want %h at +%0d",
                 i, wq[i], wc[i] - start, rot_exp[i], 4 * (i + 1));
      end
    end
  endtask

  task automatic test_bounce();
    int unsigned b_exp[16] = '{128, 64, 32, 16, 8, 4, 2, 1, 2, 4, 8, 16, 32, 64, 128, 64};
    int unsigned wq[$];
    cfg_write(2'd1, 32'd0);
    cfg_write(2'd2, 32'h40);
    cfg_write(2'd0, 32'd7);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h40) begin
      errors++; $display("FAIL bounce_load got cs=%b wd=%h want cs=1 wd=40", pio_chipselect, pio_writedata);
    end
    address = 2'd3;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      checks++;
      if (pio_chipselect !== exp_wr || pio_write_n !== !exp_wr || (exp_wr && pio_writedata !== exp_wd)) begin
        errors++;
        $display("FAIL bounce_pio cyc=%0d got cs=%b wn=%b wd=%h want cs=%b wd=%h",
                 cyc, pio_chipselect, pio_write_n, pio_writedata, exp_wr, exp_wd);
      end
      checks++;
      if (readdata !== exp_read(3)) begin
        errors++; $display("FAIL bounce_status cyc=%0d got %h want %h", cyc, readdata, exp_read(3));
      end
      if (pio_chipselect === 1'b1) wq.push_back(pio_writedata);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] != b_exp[i]) begin
        errors++;
        $display("FAIL bounce_seq[%0d] got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hFFFF_FFFF, b_exp[i]);
      end
    end
  endtask

  task automatic test_blink();
    int unsigned wq[$];
    int unsigned wc[$];
    int unsigned start;
    int nwr;
    cfg_write(2'd1, 32'd1);
    cfg_write(2'd2, 32'hA5);
    cfg_write(2'd0, 32'd3);
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      checks++;
      if (pio_chipselect !== exp_wr || pio_write_n !== !exp_wr || (exp_wr && pio_writedata !== exp_wd)) begin
        errors++;
        $display("FAIL blink_pio cyc=%0d got cs=%b wn=%b wd=%h want cs=%b wd=%h",
                 cyc, pio_chipselect, pio_write_n, pio_writedata, exp_wr, exp_wd);
      end
      if (pio_chipselect === 1'b1) begin
        wq.push_back(pio_writedata); wc.push_back(cyc);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] != ((i % 2 == 0) ? 32'h00 : 32'hA5) || wc[i] != start + 2 * (i + 1)) begin
        errors++;
        $display("FAIL blink_seq[%0d] got %h want %h at +%0d", i,
                 (i < wq.size()) ? wq[i] : 32'hFFFF_FFFF, (i % 2 == 0) ? 32'h00 : 32'hA5, 2 * (i + 1));
      end
    end
    cfg_write(2'd0, 32'd2);
    cfg_write(2'd2, 32'h3C);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_writedata !== 32'h3C) begin
      errors++;
      $display("FAIL blink_static got cs=%b wn=%b wd=%h want cs=1 wn=0 wd=3c",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    nwr = 0;
    for (int i = 0; i < 100; i++) begin
      clk_cycle();
      if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) nwr++;
    end
    checks++;
    if (nwr != 0) begin
      errors++; $display("FAIL blink_disabled_quiet got %0d writes want 0", nwr);
    end
  endtask

  task automatic test_collision();
    int n;
    cfg_write(2'd1, 32'd5);
    cfg_write(2'd2, 32'h01);
    cfg_write(2'd0, 32'd5);
    n = 0;
    while (m_since != 5 && n < 20) begin
      clk_cycle(); n++;
    end
    checks++;
    if (m_since != 5) begin
      errors++; $display("FAIL collision_align got since=%0d want 5", m_since);
    end
    cfg_write(2'd2, 32'h81);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h81) begin
      errors++; $display("FAIL collision_load got cs=%b wd=%h want cs=1 wd=81", pio_chipselect, pio_writedata);
    end
    n = 0;
    do begin
      clk_cycle(); n++;
    end while (pio_chipselect !== 1'b1 && n < 20);
    checks++;
    if (n != 6 || pio_writedata !== 32'h03) begin
      errors++; $display("FAIL collision_next got %h after %0d cycles want 03 after 6", pio_writedata, n);
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    for (int i = 0; i < 400; i++) begin
      a = 2'($urandom_range(0, 3));
      address = a;
      chipselect = 1'b0; write_n = 1'b1;
      if ($urandom_range(0, 9) < 2) begin
        chipselect = 1'b1; write_n = 1'b0;
        case (a)
          2'd0:    writedata = 32'($urandom_range(0, 7));
          2'd1:    writedata = 32'($urandom_range(0, 6));
          default: writedata = $urandom;
        endcase
      end else if ($urandom_range(0, 9) == 0) begin
        write_n = 1'b0;
        writedata = $urandom;
      end
      clk_cycle();
      chipselect = 1'b0; write_n = 1'b1;
      checks++;
      if (pio_chipselect !== exp_wr || pio_write_n !== !exp_wr || (exp_wr && pio_writedata !== exp_wd)) begin
        errors++;
        $display("FAIL random_pio cyc=%0d got cs=%b wn=%b wd=%h want cs=%b wd=%h",
                 cyc, pio_chipselect, pio_write_n, pio_writedata, exp_wr, exp_wd);
      end
      checks++;
      if (readdata !== exp_read(int'(address))) begin
        errors++;
        $display("FAIL random_read cyc=%0d addr=%0d got %h want %h", cyc, address, readdata, exp_read(int'(address)));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    cfg_write(2'd1, 32'd2);
    cfg_write(2'd0, 32'd5);
    cfg_write(2'd2, 32'h5A);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h5A) begin
      errors++; $display("FAIL midreset_pre got cs=%b wd=%h want cs=1 wd=5a", pio_chipselect, pio_writedata);
    end
    reset = 1'b1;
    clk_cycle();
    reset = 1'b0;
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin
      errors++;
      $display("FAIL midreset_strobe got cs=%b wn=%b wd=%h want cs=0 wn=1 wd=0",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    address = 2'd3; #1;
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL midreset_status got %h want 0", readdata);
    end
    address = 2'd0; #1;
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL midreset_ctrl got %h want 0", readdata);
    end
    address = 2'd1; #1;
    checks++;
    if (readdata !== 32'd24999999) begin
      errors++; $display("FAIL midreset_period got %0d want 24999999", readdata);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_blink();
    test_collision();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
